// File: rtl/sprite_fetch.sv
// Sprite fetch stage: hit-tests the scan position against a sprite box,
// issues the sprite ROM address, realigns the returned ROM word with the
// delayed hit flag, applies colour-key transparency and steps the
// animation frame once every ANIM_DIV video frames.
module sprite_fetch #(
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int FRAMES   = 2,
    parameter int WIDTH    = 4,
    parameter int CORDW    = 10,
    parameter int ANIM_DIV = 8,
    parameter int TRANSP   = 0,
    localparam int ADDRW   = $clog2(SPR_W*SPR_H*FRAMES),
    localparam int FIW     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             de,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic [CORDW-1:0] spr_x,
    input  logic [CORDW-1:0] spr_y,
    input  logic             anim_en,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] pix,
    output logic             drawing,
    output logic [FIW-1:0]   frame_idx
);

    localparam int DIVW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CORDW:0]   SPR_W_E   = (CORDW+1)'(SPR_W);
    localparam logic [CORDW:0]   SPR_H_E   = (CORDW+1)'(SPR_H);
    localparam logic [DIVW-1:0]  DIV_LAST  = DIVW'(ANIM_DIV-1);
    localparam logic [FIW-1:0]   FRM_LAST  = FIW'(FRAMES-1);
    localparam logic [WIDTH-1:0] TRANSP_C  = WIDTH'(TRANSP);

    logic [CORDW-1:0] pos_x_q, pos_x_d;
    logic [CORDW-1:0] pos_y_q, pos_y_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic [FIW-1:0]   frame_idx_q, frame_idx_d;
    logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
    logic             hit_d1_q, hit_d1_d;
    logic             hit_d2_q, hit_d2_d;
    logic [WIDTH-1:0] pix_q, pix_d;
    logic             drawing_q, drawing_d;

    logic             hit_s;
    logic [CORDW:0]   x_lo_s, x_hi_s, y_lo_s, y_hi_s, sx_e_s, sy_e_s;
    logic [CORDW-1:0] rx_s, ry_s;
    logic [31:0]      addr_full_s;

    // Hit test and ROM address; one bit of headroom keeps edge boxes from wrapping.
    always_comb begin
        sx_e_s = {1'b0, sx};
        sy_e_s = {1'b0, sy};
        x_lo_s = {1'b0, pos_x_q};
        y_lo_s = {1'b0, pos_y_q};
        x_hi_s = x_lo_s + SPR_W_E;
        y_hi_s = y_lo_s + SPR_H_E;
        hit_s  = de & (sx_e_s >= x_lo_s) & (sx_e_s < x_hi_s)
                    & (sy_e_s >= y_lo_s) & (sy_e_s < y_hi_s);
        rx_s   = sx - pos_x_q;
        ry_s   = sy - pos_y_q;
        addr_full_s = 32'(frame_idx_q) * 32'(SPR_W*SPR_H)
                    + 32'(ry_s) * 32'(SPR_W) + 32'(rx_s);
    end

    // Position latch and animation divider, both stepped only on frame_start.
    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        div_d       = div_q;
        frame_idx_d = frame_idx_q;
        if (frame_start) begin
            pos_x_d = spr_x;
            pos_y_d = spr_y;
            if (anim_en) begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (frame_idx_q == FRM_LAST) begin
                        frame_idx_d = '0;
                    end else begin
                        frame_idx_d = frame_idx_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end else begin
                div_d = div_q;
            end
        end else begin
            pos_x_d = pos_x_q;
        end
    end

    // Fetch pipeline: address issue, hit realignment with ROM data, colour key.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (hit_s) begin
            rom_addr_d = addr_full_s[ADDRW-1:0];
        end else begin
            rom_addr_d = rom_addr_q;
        end
        hit_d1_d  = hit_s;
        hit_d2_d  = hit_d1_q;
        drawing_d = hit_d2_q & (rom_data != TRANSP_C);
        if (drawing_d) begin
            pix_d = rom_data;
        end else begin
            pix_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            div_q       <= '0;
            frame_idx_q <= '0;
            rom_addr_q  <= '0;
            hit_d1_q    <= 1'b0;
            hit_d2_q    <= 1'b0;
            pix_q       <= '0;
            drawing_q   <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            div_q       <= div_d;
            frame_idx_q <= frame_idx_d;
            rom_addr_q  <= rom_addr_d;
            hit_d1_q    <= hit_d1_d;
            hit_d2_q    <= hit_d2_d;
            pix_q       <= pix_d;
            drawing_q   <= drawing_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix       = pix_q;
    assign drawing   = drawing_q;
    assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a 1-cycle synchronous ROM model.
module tb_sprite_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       de = 1'b0;
    logic [9:0] sx = 10'd0;
    logic [9:0] sy = 10'd0;
    logic [9:0] spr_x = 10'd0;
    logic [9:0] spr_y = 10'd0;
    logic       anim_en = 1'b0;
    logic [8:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] pix;
    logic       drawing;
    logic [0:0] frame_idx;

    logic [3:0] rom [0:511];
    int n_checks = 0;
    int n_fail = 0;
    int exp_addr = 0;

    sprite_fetch dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .de(de),
        .sx(sx), .sy(sy), .spr_x(spr_x), .spr_y(spr_y), .anim_en(anim_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix(pix),
        .drawing(drawing), .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse(input int x, input int y);
        frame_start = 1'b1;
        de = 1'b0;
        spr_x = 10'(x);
        spr_y = 10'(y);
        tick();
        frame_start = 1'b0;
    endtask

    // Scan n pixels of row y from x0; outputs lag the scan inputs by 3 cycles.
    task automatic scan_row(input string name, input int y, input int x0, input int n,
                            input int px, input int py, input int fidx,
                            output int ndraw, output int first_x);
        logic [3:0] ep [0:63];
        logic       ed [0:63];
        int x;
        logic [3:0] d;
        logic h;
        ndraw = 0;
        first_x = -1;
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                n_checks++;
                if (drawing !== ed[i-3]) begin
                    n_fail++;
                    $display("FAIL %s drawing x=%0d: got %b want %b", name, x0+i-3, drawing, ed[i-3]);
                end
                n_checks++;
                if (pix !== ep[i-3]) begin
                    n_fail++;
                    $display("FAIL %s pix x=%0d: got %0d want %0d", name, x0+i-3, pix, ep[i-3]);
                end
                if (drawing === 1'b1) begin
                    ndraw++;
                    if (first_x < 0) first_x = x0 + i - 3;
                end
            end
            if (i >= 1) begin
                n_checks++;
                if (rom_addr !== 9'(exp_addr)) begin
                    n_fail++;
                    $display("FAIL %s rom_addr step %0d: got %0d want %0d", name, i, rom_addr, exp_addr);
                end
            end
            if (i < n) begin
                x = x0 + i;
                de = 1'b1;
                sx = 10'(x);
                sy = 10'(y);
                h = (x >= px) && (x < px + 16) && (y >= py) && (y < py + 16);
                if (h) exp_addr = (fidx*256 + (y-py)*16 + (x-px)) & 511;
                d = rom[exp_addr];
                ed[i] = h && (d != 4'd0);
                ep[i] = ed[i] ? d : 4'd0;
            end else begin
                de = 1'b0;
            end
            tick();
        end
        de = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (rom_addr !== 9'd0) begin n_fail++; $display("FAIL reset rom_addr: got %0d want 0", rom_addr); end
        n_checks++; if (pix !== 4'd0) begin n_fail++; $display("FAIL reset pix: got %0d want 0", pix); end
        n_checks++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL reset drawing: got %b want 0", drawing); end
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL reset frame_idx: got %0d want 0", frame_idx); end
        exp_addr = 0;
    endtask

    task automatic test_rows;
        int nd, fx;
        frame_pulse(100, 50);
        scan_row("row0", 50, 98, 21, 100, 50, 0, nd, fx);
        n_checks++; if (nd !== 16) begin n_fail++; $display("FAIL row0 count: got %0d want 16", nd); end
        n_checks++; if (fx !== 100) begin n_fail++; $display("FAIL row0 first: got %0d want 100", fx); end
        n_checks++; if (rom_addr !== 9'd15) begin n_fail++; $display("FAIL row0 last addr: got %0d want 15", rom_addr); end
        scan_row("row15", 65, 98, 21, 100, 50, 0, nd, fx);
        n_checks++; if (nd !== 16) begin n_fail++; $display("FAIL row15 count: got %0d want 16", nd); end
        n_checks++; if (rom_addr !== 9'd255) begin n_fail++; $display("FAIL row15 last addr: got %0d want 255", rom_addr); end
        scan_row("row66", 66, 98, 21, 100, 50, 0, nd, fx);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL row66 count: got %0d want 0", nd); end
        scan_row("row49", 49, 98, 21, 100, 50, 0, nd, fx);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL row49 count: got %0d want 0", nd); end
    endtask

    task automatic test_transp;
        int nd, fx;
        rom[5] = 4'd0;
        scan_row("transp", 50, 98, 21, 100, 50, 0, nd, fx);
        n_checks++; if (nd !== 15) begin n_fail++; $display("FAIL transp count: got %0d want 15", nd); end
        rom[5] = 4'd5;
    endtask

    task automatic test_anim;
        int nd, fx;
        anim_en = 1'b1;
        for (int i = 0; i < 7; i++) frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL anim pulse7: got %0d want 0", frame_idx); end
        frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b1) begin n_fail++; $display("FAIL anim pulse8: got %0d want 1", frame_idx); end
        scan_row("anim_row", 50, 98, 21, 100, 50, 1, nd, fx);
        n_checks++; if (rom_addr !== 9'd271) begin n_fail++; $display("FAIL anim last addr: got %0d want 271", rom_addr); end
        for (int i = 0; i < 7; i++) frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b1) begin n_fail++; $display("FAIL anim pulse15: got %0d want 1", frame_idx); end
        frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL anim pulse16: got %0d want 0", frame_idx); end
        // Freeze after 4 pulses: the divider must resume from 4, not 0.
        for (int i = 0; i < 4; i++) frame_pulse(100, 50);
        anim_en = 1'b0;
        for (int i = 0; i < 10; i++) frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL anim frozen: got %0d want 0", frame_idx); end
        anim_en = 1'b1;
        for (int i = 0; i < 3; i++) frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL anim resume3: got %0d want 0", frame_idx); end
        frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b1) begin n_fail++; $display("FAIL anim resume4: got %0d want 1", frame_idx); end
        for (int i = 0; i < 8; i++) frame_pulse(100, 50);
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL anim back0: got %0d want 0", frame_idx); end
        anim_en = 1'b0;
    endtask

    task automatic test_edge;
        int nd, fx;
        frame_pulse(1020, 50);
        scan_row("edge_right", 50, 1016, 8, 1020, 50, 0, nd, fx);
        n_checks++; if (nd !== 4) begin n_fail++; $display("FAIL edge count: got %0d want 4", nd); end
        n_checks++; if (fx !== 1020) begin n_fail++; $display("FAIL edge first: got %0d want 1020", fx); end
        scan_row("edge_wrap", 50, 0, 12, 1020, 50, 0, nd, fx);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL wrap count: got %0d want 0", nd); end
    endtask

    task automatic test_coincident;
        // Old latch (1020,50) must apply on the frame_start cycle itself.
        frame_start = 1'b1; spr_x = 10'd100; spr_y = 10'd200;
        de = 1'b1; sx = 10'd1021; sy = 10'd50;
        tick();
        frame_start = 1'b0;
        n_checks++; if (rom_addr !== 9'd1) begin n_fail++; $display("FAIL coinc addr: got %0d want 1", rom_addr); end
        tick();
        de = 1'b0;
        n_checks++; if (rom_addr !== 9'd1) begin n_fail++; $display("FAIL coinc hold addr: got %0d want 1", rom_addr); end
        tick();
        n_checks++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL coinc old drawing: got %b want 1", drawing); end
        n_checks++; if (pix !== 4'd1) begin n_fail++; $display("FAIL coinc old pix: got %0d want 1", pix); end
        tick();
        n_checks++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL coinc new drawing: got %b want 0", drawing); end
        exp_addr = 1;
    endtask

    task automatic test_mid_reset;
        int nd, fx;
        anim_en = 1'b1;
        for (int i = 0; i < 8; i++) frame_pulse(100, 50);
        anim_en = 1'b0;
        n_checks++; if (frame_idx !== 1'b1) begin n_fail++; $display("FAIL mreset pre frame_idx: got %0d want 1", frame_idx); end
        for (int i = 0; i < 5; i++) begin
            de = 1'b1; sx = 10'(100 + i); sy = 10'd50;
            tick();
        end
        n_checks++; if (drawing !== 1'b1) begin n_fail++; $display("FAIL mreset pre drawing: got %b want 1", drawing); end
        rst = 1'b1; sx = 10'd105;
        tick();
        rst = 1'b0;
        n_checks++; if (drawing !== 1'b0) begin n_fail++; $display("FAIL mreset drawing: got %b want 0", drawing); end
        n_checks++; if (pix !== 4'd0) begin n_fail++; $display("FAIL mreset pix: got %0d want 0", pix); end
        n_checks++; if (frame_idx !== 1'b0) begin n_fail++; $display("FAIL mreset frame_idx: got %0d want 0", frame_idx); end
        n_checks++; if (rom_addr !== 9'd0) begin n_fail++; $display("FAIL mreset rom_addr: got %0d want 0", rom_addr); end
        exp_addr = 0;
        scan_row("mreset_rest", 50, 106, 15, 0, 0, 0, nd, fx);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL mreset no draw: got %0d want 0", nd); end
        frame_pulse(100, 50);
        scan_row("mreset_refill", 50, 98, 21, 100, 50, 0, nd, fx);
        n_checks++; if (nd !== 16) begin n_fail++; $display("FAIL mreset refill count: got %0d want 16", nd); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 4'(i) | 4'd1;
        test_reset();
        test_rows();
        test_transp();
        test_anim();
        test_edge();
        test_coincident();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Scan-side sprite address generator and pixel stage that sits directly upstream and downstream of the synchronous sprite ROM (1-cycle read latency).
- Hit-tests the current VGA scan position against a sprite box and issues the ROM address.
- Realigns the returned ROM word with a delayed hit flag, applies colour-key transparency and steps the animation frame on a video-frame cadence.
- Output feeds the pixel mixer ahead of the VGA output register.

Parameters:
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- FRAMES, 2, animation frames stored back-to-back in the ROM.
- WIDTH, 4, ROM word / colour index width.
- CORDW, 10, screen coordinate width.
- ANIM_DIV, 8, video frames per animation step (≥1).
- TRANSP, 0, colour index treated as transparent.
- ADDRW, $clog2(SPR_W*SPR_H*FRAMES), ROM address width (derived, not overridden).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of each video frame (during blanking).
- de  in  1  display enable for current sx/sy.
- sx  in  CORDW  current scan x.
- sy  in  CORDW  current scan y.
- spr_x  in  CORDW  sprite left edge; sampled only on frame_start.
- spr_y  in  CORDW  sprite top edge; sampled only on frame_start.
- anim_en  in  1  animation advance enable.
- rom_addr  out  ADDRW  registered address to sprite ROM.
- rom_data  in  WIDTH  ROM read data, valid 1 cycle after rom_addr.
- pix  out  WIDTH  colour index; 0 when drawing low.
- drawing  out  1  opaque sprite pixel present on pix.
- frame_idx  out  $clog2(FRAMES) (min 1)  current animation frame.

Behaviour:
- Reset values:
  - rom_addr=0, pix=0, drawing=0, frame_idx=0.
  - Latched x/y=0, anim divider=0, all pipeline hit flags=0.
- Position latch: on frame_start, pos_x<=spr_x and pos_y<=spr_y; the new values apply from the next cycle. When de and frame_start coincide, the hit test that cycle uses the old latch.
- Hit test (cycle N, combinational on inputs):
  - hit = de & (sx ≥ pos_x) & (sx < pos_x+SPR_W) & (sy ≥ pos_y) & (sy < pos_y+SPR_H).
  - Compares are done at CORDW+1 bits so boxes at the right/bottom edge never wrap. A sprite partly off-screen is simply clipped.
- Address:
  - rx=sx-pos_x, ry=sy-pos_y.
  - addr = frame_idx*SPR_W*SPR_H + ry*SPR_W + rx, truncated to ADDRW.
  - Registered into rom_addr at N+1 only when hit; otherwise rom_addr holds its value.
- Pipeline:
  - hit_d1 at N+1, hit_d2 at N+2 (aligned with rom_data).
  - At N+3: drawing <= hit_d2 & (rom_data != TRANSP); pix <= drawing-next ? rom_data : 0.
  - Fixed latency 3 cycles from sx/sy/de to pix/drawing. The scan driver compensates.
- Animation:
  - Divider counts frame_start pulses while anim_en=1.
  - When the divider reaches ANIM_DIV-1 on a frame_start: divider<=0 and frame_idx increments, wrapping FRAMES-1 -> 0.
  - anim_en=0 freezes both divider and frame_idx (no reset of the divider).
  - frame_idx changes only on frame_start, so a whole frame uses one animation frame.
- Reset mid-frame:
  - Outputs go to reset values on the cycle after rst.
  - No drawing until the pipeline refills (≥3 cycles after rst deasserts, and after the first frame_start for a non-zero position).
- rom_data is never sampled outside hit_d2; garbage on rom_data with hit_d2=0 must not reach pix.

Test Plan:
- Reset, frame_start with spr_x=100, spr_y=50; scan row sy=50 from sx=98..118 with ROM pre-loaded rom[i]=i[3:0]|1 -> drawing high for exactly 16 cycles, starting 3 cycles after sx=100; pix sequence 1,1,3,3,5,... matching addresses 0..15; rom_addr=0..15.
- Same setup, sy=65 -> addresses 240..255. At sy=66 and at sy=49, drawing never asserts.
- ROM word TRANSP (0) at rel (5,0) -> drawing low and pix=0 for that single cycle only; neighbours unaffected.
- anim_en=1, ANIM_DIV=8, FRAMES=2: issue 16 frame_start pulses -> frame_idx toggles after pulses 8 and 16 (0->1->0). After the first toggle, row 0 addresses become 256..271. Dropping anim_en after pulse 4 holds frame_idx=0 and divider=4.
- spr_x=1020 (CORDW=10), scan sx up to 1023 -> hit only at sx=1020..1023, no wrap hit at sx=0..11. spr_y update with de and frame_start coincident -> old position used that cycle.
- Assert rst for 1 cycle mid-sprite-row -> drawing=0, pix=0, frame_idx=0 next cycle; no drawing until after the next frame_start re-latches the position.
